// File: rtl/host_adapter_strobe_decoder.sv
// host_adapter_strobe_decoder
// Clocked 1MHz-bus page decoder. Synchronises and glitch-qualifies the bus
// enable, decodes a window of NUM_REGS registers above BASE_ADDR in page &FC
// with per-register read/write permission, and produces a level read select
// plus single-clock end-of-access strobes so downstream logic acts exactly
// once per bus cycle.
// Ports:
//   fastClock, nReset  : system clock, async active-low reset
//   bbc_ADDRESS        : bus address low byte
//   cleanPGFC          : page &FC select (active high)
//   n1MHZE             : bus enable, active low, asynchronous to fastClock
//   nRW                : 1 = read, 0 = write
//   readSelect         : one-hot level during a qualified permitted read
//   readStrobe         : one-hot pulse at the end of a permitted read
//   writeStrobe        : one-hot pulse at the end of a permitted write
//   busActive          : high while a decoded access is in progress
//   timeoutError       : pulse when an access overruns TIMEOUT clocks
module host_adapter_strobe_decoder #(
  parameter logic [7:0]  BASE_ADDR   = 8'h40,
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [15:0] READ_MASK   = 16'h0003,
  parameter logic [15:0] WRITE_MASK  = 16'h001D,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_LOW     = 3,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                fastClock,
  input  logic                nReset,
  input  logic [7:0]          bbc_ADDRESS,
  input  logic                cleanPGFC,
  input  logic                n1MHZE,
  input  logic                nRW,
  output logic [NUM_REGS-1:0] readSelect,
  output logic [NUM_REGS-1:0] readStrobe,
  output logic [NUM_REGS-1:0] writeStrobe,
  output logic                busActive,
  output logic                timeoutError
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_QUALIFY = 2'd1;
  localparam logic [1:0] S_ACTIVE  = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  localparam logic [3:0] MIN_LOW_W  = 4'(MIN_LOW);
  localparam logic [9:0] TIMEOUT_W  = 10'(TIMEOUT);
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   e_sync;

  logic [1:0]          state_q, state_d;
  logic [3:0]          low_cnt_q, low_cnt_d;
  logic [9:0]          act_cnt_q, act_cnt_d;
  logic [3:0]          off_q, off_d;
  logic                rd_q, rd_d;
  logic [NUM_REGS-1:0] rsel_q, rsel_d;
  logic [NUM_REGS-1:0] rstb_q, rstb_d;
  logic [NUM_REGS-1:0] wstb_q, wstb_d;
  logic                bact_q, bact_d;
  logic                tmo_q, tmo_d;

  logic [8:0]          diff_c;
  logic                hit_c;
  logic                decide_c;

  // Enable synchroniser; idles high so reset looks like a quiet bus.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], n1MHZE};
  assign e_sync = sync_q[SYNC_STAGES-1];

  // Window decode; bit 8 of the 9-bit difference is the borrow (below base).
  assign diff_c = {1'b0, bbc_ADDRESS} - {1'b0, BASE_ADDR};
  assign hit_c  = cleanPGFC && !diff_c[8] && (diff_c < NUM_REGS_W) &&
                  (nRW ? READ_MASK[diff_c[3:0]] : WRITE_MASK[diff_c[3:0]]);

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    low_cnt_d = low_cnt_q;
    act_cnt_d = act_cnt_q;
    off_d     = off_q;
    rd_d      = rd_q;
    rsel_d    = '0;
    rstb_d    = '0;
    wstb_d    = '0;
    tmo_d     = 1'b0;
    decide_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!e_sync) begin
          // The first low clock already counts towards MIN_LOW.
          if (MIN_LOW_W == 4'd1) begin
            decide_c = 1'b1;
          end else begin
            state_d   = S_QUALIFY;
            low_cnt_d = 4'd1;
          end
        end
      end
      S_QUALIFY: begin
        if (e_sync) begin
          state_d   = S_IDLE;
          low_cnt_d = '0;
        end else if ((low_cnt_q + 4'd1) == MIN_LOW_W) begin
          decide_c = 1'b1;
        end else begin
          low_cnt_d = low_cnt_q + 4'd1;
        end
      end
      S_ACTIVE: begin
        act_cnt_d = act_cnt_q + 10'd1;
        // End of cycle takes priority over a coincident timeout.
        if (e_sync) begin
          state_d = S_IDLE;
          if (rd_q) rstb_d = NUM_REGS'(1) << off_q;
          else      wstb_d = NUM_REGS'(1) << off_q;
        end else if (act_cnt_d == TIMEOUT_W) begin
          state_d = S_RECOVER;
          tmo_d   = 1'b1;
        end else if (rd_q) begin
          rsel_d = NUM_REGS'(1) << off_q;
        end
      end
      S_RECOVER: begin
        if (e_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Qualified cycle: sample the bus mid-cycle and latch offset/direction.
    if (decide_c) begin
      low_cnt_d = '0;
      if (hit_c) begin
        state_d   = S_ACTIVE;
        act_cnt_d = '0;
        off_d     = diff_c[3:0];
        rd_d      = nRW;
        if (nRW) rsel_d = NUM_REGS'(1) << diff_c[3:0];
      end else begin
        state_d = S_RECOVER;
      end
    end

    bact_d = (state_d == S_ACTIVE);
  end

  // State and registered outputs.
  always_ff @(posedge fastClock or negedge nReset) begin
    if (!nReset) begin
      sync_q    <= '1;
      state_q   <= S_IDLE;
      low_cnt_q <= '0;
      act_cnt_q <= '0;
      off_q     <= '0;
      rd_q      <= 1'b0;
      rsel_q    <= '0;
      rstb_q    <= '0;
      wstb_q    <= '0;
      bact_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      low_cnt_q <= low_cnt_d;
      act_cnt_q <= act_cnt_d;
      off_q     <= off_d;
      rd_q      <= rd_d;
      rsel_q    <= rsel_d;
      rstb_q    <= rstb_d;
      wstb_q    <= wstb_d;
      bact_q    <= bact_d;
      tmo_q     <= tmo_d;
    end
  end

  assign readSelect   = rsel_q;
  assign readStrobe   = rstb_q;
  assign writeStrobe  = wstb_q;
  assign busActive    = bact_q;
  assign timeoutError = tmo_q;

endmodule

// File: tb/tb_host_adapter_strobe_decoder.sv
// Directed bench for host_adapter_strobe_decoder: one instance with default
// parameters and one with TIMEOUT = 20, both driven from the same bus.
module tb_host_adapter_strobe_decoder;

  logic       fastClock = 1'b0;
  logic       nReset;
  logic [7:0] bbc_ADDRESS;
  logic       cleanPGFC;
  logic       n1MHZE;
  logic       nRW;

  logic [7:0] rsel, rstb, wstb;
  logic       bact, tmo;
  logic [7:0] t_rsel, t_rstb, t_wstb;
  logic       t_bact, t_tmo;

  int checks = 0;
  int passes = 0;

  // Per-bus-cycle observations
  int         ws_cnt, rs_cnt, stb_j, rsel_first, bact_cnt, tmo_cnt;
  int         overlap, onehot_bad, cur_low;
  logic [7:0] last_ws, last_rs, rsel_at_stb, rsel_at_l;
  int         t_tmo_cnt, t_tmo_edge, t_rs_cnt, t_rsel_last;
  logic [7:0] t_last_rs;

  always #5 fastClock = ~fastClock;

  host_adapter_strobe_decoder dut (
    .fastClock(fastClock), .nReset(nReset), .bbc_ADDRESS(bbc_ADDRESS),
    .cleanPGFC(cleanPGFC), .n1MHZE(n1MHZE), .nRW(nRW),
    .readSelect(rsel), .readStrobe(rstb), .writeStrobe(wstb),
    .busActive(bact), .timeoutError(tmo)
  );

  host_adapter_strobe_decoder #(.TIMEOUT(20)) dut_t (
    .fastClock(fastClock), .nReset(nReset), .bbc_ADDRESS(bbc_ADDRESS),
    .cleanPGFC(cleanPGFC), .n1MHZE(n1MHZE), .nRW(nRW),
    .readSelect(t_rsel), .readStrobe(t_rstb), .writeStrobe(t_wstb),
    .busActive(t_bact), .timeoutError(t_tmo)
  );

  task automatic clear_mon();
    ws_cnt = 0; rs_cnt = 0; stb_j = 0; rsel_first = 0; bact_cnt = 0;
    tmo_cnt = 0; overlap = 0; onehot_bad = 0;
    last_ws = '0; last_rs = '0; rsel_at_stb = '0; rsel_at_l = '0;
    t_tmo_cnt = 0; t_tmo_edge = 0; t_rs_cnt = 0; t_rsel_last = 0; t_last_rs = '0;
  endtask

  // hi = 0: k-th edge after n1MHZE fell; hi = 1: k-th edge after it rose.
  task automatic sample(input bit hi, input int k);
    if (wstb != 8'h00) begin
      ws_cnt++; last_ws = wstb; stb_j = hi ? k : -k;
    end
    if (rstb != 8'h00) begin
      rs_cnt++; last_rs = rstb; rsel_at_stb = rsel; stb_j = hi ? k : -k;
    end
    if (rstb != 8'h00 && wstb != 8'h00) overlap++;
    if (!$onehot0(rsel) || !$onehot0(rstb) || !$onehot0(wstb)) onehot_bad++;
    if (!hi && rsel != 8'h00 && rsel_first == 0) rsel_first = k;
    if (!hi && k == cur_low) rsel_at_l = rsel;
    if (bact) bact_cnt++;
    if (tmo) tmo_cnt++;
    if (t_tmo) begin t_tmo_cnt++; t_tmo_edge = hi ? -k : k; end
    if (t_rstb != 8'h00) begin t_rs_cnt++; t_last_rs = t_rstb; end
    if (!hi && t_rsel != 8'h00) t_rsel_last = k;
  endtask

  task automatic bus_cycle(input logic [7:0] addr, input logic rw, input logic pg,
                           input int low_clks, input int high_clks, input bit scramble);
    clear_mon();
    cur_low     = low_clks;
    bbc_ADDRESS = addr;
    nRW         = rw;
    cleanPGFC   = pg;
    n1MHZE      = 1'b0;
    for (int k = 1; k <= low_clks; k++) begin
      @(posedge fastClock); #1;
      sample(1'b0, k);
      if (scramble && k == 6) begin
        bbc_ADDRESS = 8'h48; nRW = ~rw; cleanPGFC = 1'b0;
      end
    end
    n1MHZE = 1'b1;
    for (int k = 1; k <= high_clks; k++) begin
      @(posedge fastClock); #1;
      sample(1'b1, k);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0; n1MHZE = 1'b1; nRW = 1'b1; cleanPGFC = 1'b0; bbc_ADDRESS = 8'h00;
    repeat (3) @(posedge fastClock);
    #1;
    checks++;
    if ({rsel, rstb, wstb, bact, tmo} !== 26'd0)
      $display("FAIL reset_outputs: got %h expected 0", {rsel, rstb, wstb, bact, tmo});
    else passes++;
    checks++;
    if ({t_rsel, t_rstb, t_wstb, t_bact, t_tmo} !== 26'd0)
      $display("FAIL reset_outputs_t: got %h expected 0", {t_rsel, t_rstb, t_wstb, t_bact, t_tmo});
    else passes++;
    nReset = 1'b1;
    repeat (4) @(posedge fastClock);
    #1;
    checks++;
    if ({rsel, rstb, wstb, bact, tmo} !== 26'd0)
      $display("FAIL idle_after_reset: got %h expected 0", {rsel, rstb, wstb, bact, tmo});
    else passes++;
  endtask

  task automatic test_write();
    bus_cycle(8'h44, 1'b0, 1'b1, 50, 6, 1'b0);
    checks++; if (ws_cnt !== 1) $display("FAIL wr44_count: got %0d expected 1", ws_cnt); else passes++;
    checks++; if (last_ws !== 8'h10) $display("FAIL wr44_bits: got %h expected 10", last_ws); else passes++;
    checks++; if (stb_j !== 3) $display("FAIL wr44_latency: got %0d expected 3", stb_j); else passes++;
    checks++; if (rs_cnt + rsel_first !== 0) $display("FAIL wr44_no_read: got %0d expected 0", rs_cnt + rsel_first); else passes++;
    checks++; if (bact_cnt !== 48) $display("FAIL wr44_busactive: got %0d expected 48", bact_cnt); else passes++;
    bus_cycle(8'h41, 1'b0, 1'b1, 10, 5, 1'b0);
    checks++; if (ws_cnt + bact_cnt !== 0) $display("FAIL wr41_denied: got %0d expected 0", ws_cnt + bact_cnt); else passes++;
  endtask

  task automatic test_read();
    bus_cycle(8'h41, 1'b1, 1'b1, 50, 6, 1'b0);
    checks++; if (rsel_first !== 5) $display("FAIL rd41_select_rise: got %0d expected 5", rsel_first); else passes++;
    checks++; if (rsel_at_l !== 8'h02) $display("FAIL rd41_select_level: got %h expected 02", rsel_at_l); else passes++;
    checks++; if (rs_cnt !== 1 || last_rs !== 8'h02) $display("FAIL rd41_strobe: got %0d x %h expected 1 x 02", rs_cnt, last_rs); else passes++;
    checks++; if (stb_j !== 3) $display("FAIL rd41_latency: got %0d expected 3", stb_j); else passes++;
    checks++; if (rsel_at_stb !== 8'h00) $display("FAIL rd41_select_drop: got %h expected 00", rsel_at_stb); else passes++;
    checks++; if (ws_cnt !== 0) $display("FAIL rd41_no_write: got %0d expected 0", ws_cnt); else passes++;
    bus_cycle(8'h42, 1'b1, 1'b1, 20, 5, 1'b0);
    checks++; if (rs_cnt + ws_cnt + rsel_first + bact_cnt !== 0)
      $display("FAIL rd42_denied: got %0d expected 0", rs_cnt + ws_cnt + rsel_first + bact_cnt); else passes++;
    // Address/direction/page change after sampling must not affect the cycle
    bus_cycle(8'h40, 1'b1, 1'b1, 15, 5, 1'b1);
    checks++; if (rs_cnt !== 1 || last_rs !== 8'h01 || ws_cnt !== 0)
      $display("FAIL rd40_hold: got rs=%0d bits=%h ws=%0d expected 1 01 0", rs_cnt, last_rs, ws_cnt); else passes++;
  endtask

  task automatic test_glitch_window();
    bus_cycle(8'h44, 1'b0, 1'b1, 2, 6, 1'b0);
    checks++; if (ws_cnt + bact_cnt !== 0) $display("FAIL glitch2: got %0d expected 0", ws_cnt + bact_cnt); else passes++;
    bus_cycle(8'h44, 1'b0, 1'b1, 3, 6, 1'b0);
    checks++; if (ws_cnt !== 1 || last_ws !== 8'h10) $display("FAIL minlow3: got %0d x %h expected 1 x 10", ws_cnt, last_ws); else passes++;
    bus_cycle(8'h3F, 1'b1, 1'b1, 10, 5, 1'b0);
    checks++; if (rs_cnt + ws_cnt + bact_cnt !== 0) $display("FAIL addr3f: got %0d expected 0", rs_cnt + ws_cnt + bact_cnt); else passes++;
    bus_cycle(8'h48, 1'b0, 1'b1, 10, 5, 1'b0);
    checks++; if (rs_cnt + ws_cnt + bact_cnt !== 0) $display("FAIL addr48: got %0d expected 0", rs_cnt + ws_cnt + bact_cnt); else passes++;
    bus_cycle(8'h40, 1'b1, 1'b0, 10, 5, 1'b0);
    checks++; if (rs_cnt + ws_cnt + bact_cnt !== 0) $display("FAIL nopage: got %0d expected 0", rs_cnt + ws_cnt + bact_cnt); else passes++;
  endtask

  task automatic test_timeout();
    bus_cycle(8'h40, 1'b1, 1'b1, 40, 6, 1'b0);
    checks++; if (t_tmo_cnt !== 1 || t_tmo_edge !== 25) $display("FAIL tmo_pulse: got %0d at %0d expected 1 at 25", t_tmo_cnt, t_tmo_edge); else passes++;
    checks++; if (t_rsel_last !== 24) $display("FAIL tmo_select_drop: got %0d expected 24", t_rsel_last); else passes++;
    checks++; if (t_rs_cnt !== 0) $display("FAIL tmo_no_strobe: got %0d expected 0", t_rs_cnt); else passes++;
    checks++; if (tmo_cnt !== 0 || rs_cnt !== 1) $display("FAIL default_no_tmo: got tmo=%0d rs=%0d expected 0 1", tmo_cnt, rs_cnt); else passes++;
    bus_cycle(8'h40, 1'b1, 1'b1, 22, 6, 1'b0);
    checks++; if (t_rs_cnt !== 1 || t_tmo_cnt !== 0) $display("FAIL tmo_tie_rise_wins: got rs=%0d tmo=%0d expected 1 0", t_rs_cnt, t_tmo_cnt); else passes++;
    bus_cycle(8'h40, 1'b1, 1'b1, 23, 6, 1'b0);
    checks++; if (t_rs_cnt !== 0 || t_tmo_cnt !== 1 || t_tmo_edge !== -2)
      $display("FAIL tmo_one_late: got rs=%0d tmo=%0d at %0d expected 0 1 -2", t_rs_cnt, t_tmo_cnt, t_tmo_edge); else passes++;
    bus_cycle(8'h41, 1'b1, 1'b1, 10, 5, 1'b0);
    checks++; if (t_rs_cnt !== 1 || t_last_rs !== 8'h02) $display("FAIL tmo_recovery: got %0d x %h expected 1 x 02", t_rs_cnt, t_last_rs); else passes++;
  endtask

  task automatic test_reset_mid_read();
    bbc_ADDRESS = 8'h40; nRW = 1'b1; cleanPGFC = 1'b1; n1MHZE = 1'b0;
    repeat (8) @(posedge fastClock);
    #1;
    checks++; if (rsel !== 8'h01 || bact !== 1'b1) $display("FAIL rst_pre_active: got %h %b expected 01 1", rsel, bact); else passes++;
    #2 nReset = 1'b0;
    #1;
    checks++; if ({rsel, rstb, wstb, bact, tmo} !== 26'd0)
      $display("FAIL rst_async_clear: got %h expected 0", {rsel, rstb, wstb, bact, tmo}); else passes++;
    repeat (2) @(posedge fastClock);
    #1 nReset = 1'b1;
    @(posedge fastClock);
    #1 n1MHZE = 1'b1;
    clear_mon();
    cur_low = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge fastClock); #1;
      sample(1'b1, k);
    end
    checks++; if (rs_cnt + ws_cnt + bact_cnt + t_rs_cnt !== 0)
      $display("FAIL rst_no_strobe: got %0d expected 0", rs_cnt + ws_cnt + bact_cnt + t_rs_cnt); else passes++;
  endtask

  task automatic test_back_to_back();
    int tot_ws, tot_rs, bad, ovl;
    tot_ws = 0; tot_rs = 0; bad = 0; ovl = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) begin
        bus_cycle(8'h43, 1'b0, 1'b1, 6, 4, 1'b0);
        if (ws_cnt != 1 || last_ws != 8'h08 || rs_cnt != 0) bad++;
      end else begin
        bus_cycle(8'h40, 1'b1, 1'b1, 6, 4, 1'b0);
        if (rs_cnt != 1 || last_rs != 8'h01 || ws_cnt != 0) bad++;
      end
      tot_ws += ws_cnt;
      tot_rs += rs_cnt;
      ovl    += overlap + onehot_bad;
    end
    checks++; if (tot_ws !== 50) $display("FAIL b2b_writes: got %0d expected 50", tot_ws); else passes++;
    checks++; if (tot_rs !== 50) $display("FAIL b2b_reads: got %0d expected 50", tot_rs); else passes++;
    checks++; if (bad !== 0) $display("FAIL b2b_bad_cycles: got %0d expected 0", bad); else passes++;
    checks++; if (ovl !== 0) $display("FAIL b2b_overlap: got %0d expected 0", ovl); else passes++;
  endtask

  initial begin
    clear_mon();
    cur_low = 0;
    test_reset();
    test_write();
    test_read();
    test_glitch_window();
    test_timeout();
    test_reset_mid_read();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
